// File: rtl/csa_resolve_acc.sv
// Resolves redundant (sum, carry) beats with a carry-propagate add, then accumulates them per packet.
// Optional CSA_RESOLVE_ACC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module csa_resolve_acc #(
    parameter int IN_SIZE  = 16,
    parameter int ACC_SIZE = 32,
    parameter int CNT_SIZE = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [IN_SIZE-1:0]  sum_i,
    input  logic [IN_SIZE-1:0]  carry_i,
    input  logic                last_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [ACC_SIZE-1:0] acc_o,
    output logic [CNT_SIZE-1:0] beats_o,
    output logic                ovf_o
);

    localparam int SUM_W = ACC_SIZE + 1;

    logic [IN_SIZE:0]    s1_data;
    logic                s1_last;
    logic                s1_val;
    logic                out_free;
    logic                s1_drain;
    logic                accept;

    logic                first;
    logic [ACC_SIZE-1:0] acc;
    logic [CNT_SIZE-1:0] cnt;
    logic                ovf;

    logic [ACC_SIZE-1:0] acc_base;
    logic [SUM_W-1:0]    sum_wide;
    logic [ACC_SIZE-1:0] acc_nxt;
    logic [CNT_SIZE-1:0] cnt_nxt;
    logic                ovf_nxt;

    // A last beat may only leave S1 when the output register can take its result.
    assign out_free   = !out_valid_o || out_ready_i;
    assign s1_drain   = s1_val && (!s1_last || out_free);
    assign in_ready_o = !(s1_val && !s1_drain);
    assign accept     = in_valid_i && in_ready_o;

    // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        acc_base = first ? '0 : acc;
        sum_wide = {1'b0, acc_base} + SUM_W'(s1_data);
        ovf_nxt  = (!first && ovf) || sum_wide[ACC_SIZE];
`ifdef CSA_RESOLVE_ACC_SATURATE_EN
        acc_nxt  = sum_wide[ACC_SIZE] ? '1 : sum_wide[ACC_SIZE-1:0];
`else
        acc_nxt  = sum_wide[ACC_SIZE-1:0];
`endif
        if (first) begin
            cnt_nxt = CNT_SIZE'(1);
        end else if (&cnt) begin
            cnt_nxt = cnt;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_val  <= 1'b0;
            s1_last <= 1'b0;
            s1_data <= '0;
        end else if (accept) begin
            s1_val  <= 1'b1;
            s1_last <= last_i;
            s1_data <= {1'b0, sum_i} + {1'b0, carry_i};
        end else if (s1_drain) begin
            s1_val  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            first <= 1'b1;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (s1_drain) begin
            first <= s1_last;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    // A new result overwrites the register in the same cycle the old one is taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            acc_o       <= '0;
            beats_o     <= '0;
            ovf_o       <= 1'b0;
        end else if (s1_drain && s1_last) begin
            out_valid_o <= 1'b1;
            acc_o       <= acc_nxt;
            beats_o     <= cnt_nxt;
            ovf_o       <= ovf_nxt;
        end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_csa_resolve_acc.sv
// Directed self-checking bench for csa_resolve_acc: a default-width instance and an
// ACC_SIZE=18 instance share inputs; the narrow one exercises overflow.
module tb_csa_resolve_acc;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic [15:0] sum_i;
    logic [15:0] carry_i;
    logic        last_i;
    logic        out_ready_i;

    logic        in_ready_o;
    logic        out_valid_o;
    logic [31:0] acc_o;
    logic [15:0] beats_o;
    logic        ovf_o;

    logic        n_in_ready;
    logic        n_out_valid;
    logic [17:0] n_acc;
    logic [15:0] n_beats;
    logic        n_ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    csa_resolve_acc dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .sum_i(sum_i), .carry_i(carry_i), .last_i(last_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .acc_o(acc_o), .beats_o(beats_o), .ovf_o(ovf_o)
    );

    csa_resolve_acc #(.IN_SIZE(16), .ACC_SIZE(18), .CNT_SIZE(16)) dut_n (
        .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(n_in_ready),
        .sum_i(sum_i), .carry_i(carry_i), .last_i(last_i), .out_valid_o(n_out_valid),
        .out_ready_i(out_ready_i), .acc_o(n_acc), .beats_o(n_beats), .ovf_o(n_ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Presents one beat for one edge; the beat must be acceptable at that edge.
    task automatic beat(input logic [15:0] s, input logic [15:0] c, input logic l);
        in_valid_i = 1'b1;
        sum_i      = s;
        carry_i    = c;
        last_i     = l;
        #1;
        check("beat_in_ready", in_ready_o, 1'b1);
        tick();
        in_valid_i = 1'b0;
        last_i     = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] a,
                             input logic [15:0] b, input logic o);
        check({tag, "_valid"}, out_valid_o, v);
        if (v) begin
            check({tag, "_acc"}, acc_o, a);
            check({tag, "_beats"}, beats_o, b);
            check({tag, "_ovf"}, ovf_o, o);
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #3;
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        sum_i       = '0;
        carry_i     = '0;
        last_i      = 1'b0;
        out_ready_i = 1'b1;
        tick();
        tick();
        check("rst_out_valid", out_valid_o, 1'b0);
        check("rst_acc", acc_o, 32'h0);
        check("rst_beats", beats_o, 16'h0);
        check("rst_ovf", ovf_o, 1'b0);
        check("rst_in_ready", in_ready_o, 1'b1);
        #2 rst_ni = 1'b1;
        tick();

        // Single beat: result one edge after acceptance, gone after consumption.
        beat(16'h0003, 16'h0005, 1'b1);
        check("t1_latency", out_valid_o, 1'b0);
        tick();
        check_out("t1", 1'b1, 32'h8, 16'd1, 1'b0);
        tick();
        check("t1_consumed", out_valid_o, 1'b0);

        // Four-beat packet, back-to-back and then with input gaps.
        for (int i = 0; i < 4; i++) beat(16'hFFFF, 16'h0001, i == 3);
        tick();
        check_out("t2a", 1'b1, 32'h40000, 16'd4, 1'b0);
        tick();
        beat(16'hFFFF, 16'h0001, 1'b0);
        beat(16'hFFFF, 16'h0001, 1'b0);
        tick();
        tick();
        check("t2_gap_no_result", out_valid_o, 1'b0);
        beat(16'hFFFF, 16'h0001, 1'b0);
        beat(16'hFFFF, 16'h0001, 1'b1);
        tick();
        check_out("t2b", 1'b1, 32'h40000, 16'd4, 1'b0);
        tick();

        // Backpressure: A pending, B's last beat stalls in S1.
        out_ready_i = 1'b0;
        beat(16'h0010, 16'h0020, 1'b1);
        tick();
        check_out("t3_a", 1'b1, 32'h30, 16'd1, 1'b0);
        beat(16'h0001, 16'h0001, 1'b0);
        beat(16'h0002, 16'h0002, 1'b1);
        check("t3_stall_ready", in_ready_o, 1'b0);
        check_out("t3_a_hold1", 1'b1, 32'h30, 16'd1, 1'b0);
        tick();
        check("t3_stall_ready2", in_ready_o, 1'b0);
        check_out("t3_a_hold2", 1'b1, 32'h30, 16'd1, 1'b0);
        out_ready_i = 1'b1;
        #1;
        check("t3_ready_comb", in_ready_o, 1'b1);
        tick();
        check_out("t3_b", 1'b1, 32'h6, 16'd2, 1'b0);
        tick();
        check("t3_b_consumed", out_valid_o, 1'b0);

        // Overflow on the 18-bit instance; the 32-bit instance holds the true sum.
        for (int i = 0; i < 3; i++) beat(16'hFFFF, 16'hFFFF, i == 2);
        tick();
        check_out("t4_wide", 1'b1, 32'h5FFFA, 16'd3, 1'b0);
        check("t4_n_valid", n_out_valid, 1'b1);
`ifdef CSA_RESOLVE_ACC_SATURATE_EN
        check("t4_n_acc", n_acc, 18'h3FFFF);
`else
        check("t4_n_acc", n_acc, 18'h1FFFA);
`endif
        check("t4_n_ovf", n_ovf, 1'b1);
        check("t4_n_beats", n_beats, 16'd3);
        tick();

        // Overflow flag must clear at the next packet.
        beat(16'h0001, 16'h0000, 1'b1);
        tick();
        check("t4_n_ovf_clear", n_ovf, 1'b0);
        check("t4_n_acc_next", n_acc, 18'h1);
        tick();

        // Reset mid-packet with a pending result.
        out_ready_i = 1'b0;
        beat(16'h0005, 16'h0005, 1'b1);
        tick();
        check("t5_pending", out_valid_o, 1'b1);
        beat(16'h0001, 16'h0001, 1'b0);
        beat(16'h0001, 16'h0001, 1'b0);
        rst_ni = 1'b0;
        #2;
        check("t5_rst_valid", out_valid_o, 1'b0);
        check("t5_rst_acc", acc_o, 32'h0);
        check("t5_rst_beats", beats_o, 16'h0);
        check("t5_rst_ovf", ovf_o, 1'b0);
        check("t5_rst_in_ready", in_ready_o, 1'b1);
        rst_ni      = 1'b1;
        out_ready_i = 1'b1;
        tick();
        beat(16'h0001, 16'h0001, 1'b1);
        tick();
        check_out("t5_after", 1'b1, 32'h2, 16'd1, 1'b0);
        tick();

        // Back-to-back packets of 1, 3 and 2 beats with continuous input.
        beat(16'h0001, 16'h0000, 1'b1);
        check("t6_e1", out_valid_o, 1'b0);
        beat(16'h0002, 16'h0000, 1'b0);
        check_out("t6_p1", 1'b1, 32'h1, 16'd1, 1'b0);
        beat(16'h0003, 16'h0000, 1'b0);
        check("t6_e3", out_valid_o, 1'b0);
        beat(16'h0004, 16'h0000, 1'b1);
        check("t6_e4", out_valid_o, 1'b0);
        beat(16'h0005, 16'h0000, 1'b0);
        check_out("t6_p2", 1'b1, 32'h9, 16'd3, 1'b0);
        beat(16'h0006, 16'h0000, 1'b1);
        check("t6_e6", out_valid_o, 1'b0);
        tick();
        check_out("t6_p3", 1'b1, 32'hB, 16'd2, 1'b0);
        tick();
        check("t6_e8", out_valid_o, 1'b0);

        do_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
